// File: rtl/clock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// clock_mode_ctrl
//   Key-driven mode controller for a digital clock. Two raw, bouncy,
//   active-low keys (MODE, INC) are synchronized and debounced. Their press
//   events step a NORMAL -> ADJ_HOUR -> ADJ_MIN -> NORMAL state machine.
//   While adjusting, the FSM issues increment pulses, blinks the digits being
//   adjusted, and falls back to NORMAL after TIMEOUT_S idle seconds.
//
// Parameters
//   DB_CYCLES  clocks a synchronized key level must disagree with the
//              debounced level before it is accepted
//   TIMEOUT_S  sec_tick count without a key event before an adjust state exits
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   key_mode   raw MODE key, active-low, asynchronous to clk
//   key_inc    raw INC key, active-low, asynchronous to clk
//   sec_tick   one-clock pulse per second
//   mode       00 NORMAL, 01 ADJ_HOUR, 10 ADJ_MIN
//   run_en     time counter advance enable (1 only in NORMAL)
//   hour_inc   one-clock pulse: increment hours
//   min_inc    one-clock pulse: increment minutes
//   sec_clr    one-clock pulse: clear seconds (on ADJ_MIN -> NORMAL by MODE)
//   blink_mask per-digit blank request, [5:4] hours, [3:2] minutes, [1:0] secs
// -----------------------------------------------------------------------------
module clock_mode_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       sec_tick,
  output logic [1:0] mode,
  output logic       run_en,
  output logic       hour_inc,
  output logic       min_inc,
  output logic       sec_clr,
  output logic [5:0] blink_mask
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int IDW = $clog2(TIMEOUT_S + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [IDW-1:0] IDLE_MAX = IDW'(TIMEOUT_S);

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'b00,
    ST_ADJ_HOUR = 2'b01,
    ST_ADJ_MIN  = 2'b10
  } state_t;

  // Key index 0 = MODE, 1 = INC.
  logic [1:0]     keys;
  logic [1:0]     sync1, sync2, db_lvl, press;
  logic [DBW-1:0] db_cnt [2];

  assign keys = {key_inc, key_mode};

  // Synchronizer + debouncer. The press pulse is registered on the same edge
  // the debounced level falls, so the FSM reacts one clock later.
  // NOTE: every register in this file uses non-blocking assignments so all
  // flops sample pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '1;
      sync2  <= '1;
      db_lvl <= '1;
      press  <= '0;
      for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      for (int k = 0; k < 2; k++) begin
        press[k] <= 1'b0;
        if (sync2[k] == db_lvl[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          db_lvl[k] <= sync2[k];
          db_cnt[k] <= '0;
          press[k]  <= ~sync2[k];  // only the 1->0 edge is an event
        end else begin
          db_cnt[k] <= db_cnt[k] + 1'b1;
        end
      end
    end
  end

  logic mode_ev, inc_ev;
  assign mode_ev = press[0];
  assign inc_ev  = press[1];

  function automatic logic [5:0] mask_for(input state_t s, input logic ph);
    logic [5:0] m;
    m = 6'b000000;
    if (ph) begin
      if (s == ST_ADJ_HOUR) m = 6'b110000;
      else if (s == ST_ADJ_MIN) m = 6'b001100;
    end
    return m;
  endfunction

  state_t         state;
  logic [IDW-1:0] idle_cnt;
  logic           blink_phase;
  logic           phase_nxt;

  assign mode      = state;
  assign phase_nxt = blink_phase ^ sec_tick;

  // Mode FSM with registered outputs. blink_mask is computed from the
  // post-edge state/phase so it changes on the same edge as blink_phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_NORMAL;
      idle_cnt    <= '0;
      blink_phase <= 1'b0;
      run_en      <= 1'b1;
      hour_inc    <= 1'b0;
      min_inc     <= 1'b0;
      sec_clr     <= 1'b0;
      blink_mask  <= '0;
    end else begin
      hour_inc <= 1'b0;
      min_inc  <= 1'b0;
      sec_clr  <= 1'b0;
      case (state)
        ST_NORMAL: begin
          idle_cnt    <= '0;
          blink_phase <= 1'b0;
          blink_mask  <= '0;
          run_en      <= 1'b1;
          if (mode_ev) begin
            state  <= ST_ADJ_HOUR;
            run_en <= 1'b0;
          end
        end
        ST_ADJ_HOUR, ST_ADJ_MIN: begin
          if (mode_ev) begin
            // MODE wins over a coincident INC, which is simply dropped.
            idle_cnt    <= '0;
            blink_phase <= 1'b0;
            blink_mask  <= '0;
            if (state == ST_ADJ_HOUR) begin
              state  <= ST_ADJ_MIN;
              run_en <= 1'b0;
            end else begin
              state   <= ST_NORMAL;
              run_en  <= 1'b1;
              sec_clr <= 1'b1;
            end
          end else if (!inc_ev && idle_cnt == IDLE_MAX) begin
            // Silent timeout: no sec_clr, no increment.
            state       <= ST_NORMAL;
            run_en      <= 1'b1;
            idle_cnt    <= '0;
            blink_phase <= 1'b0;
            blink_mask  <= '0;
          end else begin
            if (inc_ev) begin
              idle_cnt <= '0;
              if (state == ST_ADJ_HOUR) hour_inc <= 1'b1;
              else min_inc <= 1'b1;
            end else if (sec_tick && idle_cnt != IDLE_MAX) begin
              idle_cnt <= idle_cnt + 1'b1;
            end
            blink_phase <= phase_nxt;
            blink_mask  <= mask_for(state, phase_nxt);
          end
        end
        default: begin
          state       <= ST_NORMAL;
          run_en      <= 1'b1;
          idle_cnt    <= '0;
          blink_phase <= 1'b0;
          blink_mask  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode = 1'b1;
  logic       key_inc = 1'b1;
  logic       sec_tick = 1'b0;
  logic [1:0] mode;
  logic       run_en, hour_inc, min_inc, sec_clr;
  logic [5:0] blink_mask;

  clock_mode_ctrl #(.DB_CYCLES(4), .TIMEOUT_S(3)) dut (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_inc(key_inc),
    .sec_tick(sec_tick), .mode(mode), .run_en(run_en), .hour_inc(hour_inc),
    .min_inc(min_inc), .sec_clr(sec_clr), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Pulse counters and exclusivity monitor, sampled on the falling edge.
  int h_cnt = 0, m_cnt = 0, s_cnt = 0, excl_err = 0;
  always @(negedge clk) begin
    if (hour_inc) h_cnt++;
    if (min_inc)  m_cnt++;
    if (sec_clr)  s_cnt++;
    if (32'(hour_inc) + 32'(min_inc) + 32'(sec_clr) > 1) excl_err++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hold the selected keys low for n rising edges, release, then let the
  // debouncer settle.
  task automatic drive_keys(input logic km, input logic ki, input int n);
    @(negedge clk);
    key_mode = km ? 1'b0 : 1'b1;
    key_inc  = ki ? 1'b0 : 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    key_mode = 1'b1;
    key_inc  = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic tick();
    repeat (49) @(posedge clk);
    @(negedge clk);
    sec_tick = 1'b1;
    @(posedge clk);
    #1;
    sec_tick = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic       km;
    logic       ki;
    int         low;
    logic [1:0] exp_mode;
    int         dh, dm, ds;
  } vec_t;

  vec_t tbl[11];
  vec_t sb[$];

  initial begin
    int h0, m0, s0, bad, lat;
    vec_t v, e;

    tbl[0]  = '{"glitch_normal",  1'b1, 1'b0, 3, 2'b00, 0, 0, 0};
    tbl[1]  = '{"inc_normal",     1'b0, 1'b1, 6, 2'b00, 0, 0, 0};
    tbl[2]  = '{"mode_to_hour",   1'b1, 1'b0, 5, 2'b01, 0, 0, 0};
    tbl[3]  = '{"glitch_hour",    1'b1, 1'b0, 3, 2'b01, 0, 0, 0};
    tbl[4]  = '{"hour_inc_1",     1'b0, 1'b1, 5, 2'b01, 1, 0, 0};
    tbl[5]  = '{"hour_inc_2",     1'b0, 1'b1, 8, 2'b01, 1, 0, 0};
    tbl[6]  = '{"mode_to_min",    1'b1, 1'b0, 5, 2'b10, 0, 0, 0};
    tbl[7]  = '{"min_inc_1",      1'b0, 1'b1, 5, 2'b10, 0, 1, 0};
    tbl[8]  = '{"min_inc_2",      1'b0, 1'b1, 4, 2'b10, 0, 1, 0};
    tbl[9]  = '{"min_inc_3",      1'b0, 1'b1, 6, 2'b10, 0, 1, 0};
    tbl[10] = '{"mode_to_normal", 1'b1, 1'b0, 5, 2'b00, 0, 0, 1};

    // Reset state, then 100 idle clocks.
    repeat (5) @(posedge clk);
    #1;
    check("rst_mode", mode, 0);
    check("rst_run_en", run_en, 1);
    check("rst_pulses", {hour_inc, min_inc, sec_clr}, 0);
    check("rst_blink", blink_mask, 0);
    @(negedge clk);
    rst = 1'b0;
    h0 = h_cnt; m0 = m_cnt; s0 = s_cnt; bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (mode != 2'b00 || run_en != 1'b1 || blink_mask != 6'b0) bad++;
    end
    check("idle_outputs", bad, 0);
    check("idle_pulses", (h_cnt - h0) + (m_cnt - m0) + (s_cnt - s0), 0);

    // Press latency: first edge sampling low counts as edge 1.
    @(negedge clk);
    key_mode = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) key_mode = 1'b1;
      if (mode == 2'b01 && lat < 0) lat = i;
    end
    check("press_latency", lat, 7);
    check("latency_run_en", run_en, 0);
    drive_keys(1'b1, 1'b0, 5);
    drive_keys(1'b1, 1'b0, 5);
    check("back_normal", mode, 0);

    // Table-driven key vectors through the scoreboard.
    for (int i = 0; i < 11; i++) begin
      v = tbl[i];
      h0 = h_cnt; m0 = m_cnt; s0 = s_cnt;
      sb.push_back(v);
      drive_keys(v.km, v.ki, v.low);
      e = sb.pop_front();
      check({e.name, "_mode"}, mode, e.exp_mode);
      check({e.name, "_run_en"}, run_en, (e.exp_mode == 2'b00) ? 1 : 0);
      check({e.name, "_blink"}, blink_mask, 0);
      check({e.name, "_hour_inc"}, h_cnt - h0, e.dh);
      check({e.name, "_min_inc"}, m_cnt - m0, e.dm);
      check({e.name, "_sec_clr"}, s_cnt - s0, e.ds);
    end

    // Blink and silent timeout in ADJ_MIN.
    drive_keys(1'b1, 1'b0, 5);
    drive_keys(1'b1, 1'b0, 5);
    check("to_min_mode", mode, 2);
    m0 = m_cnt; s0 = s_cnt;
    tick();
    check("blink_min_tick1", blink_mask, 6'b001100);
    tick();
    check("blink_min_tick2", blink_mask, 6'b000000);
    tick();
    check("timeout_hold", mode, 2);
    @(posedge clk);
    #1;
    check("timeout_mode", mode, 0);
    check("timeout_run_en", run_en, 1);
    repeat (5) @(negedge clk);
    check("timeout_sec_clr", s_cnt - s0, 0);
    check("timeout_min_inc", m_cnt - m0, 0);

    // ADJ_HOUR blink, then MODE and INC together: MODE wins.
    drive_keys(1'b1, 1'b0, 5);
    tick();
    check("blink_hour_tick1", blink_mask, 6'b110000);
    h0 = h_cnt; m0 = m_cnt;
    drive_keys(1'b1, 1'b1, 5);
    check("both_mode", mode, 2);
    check("both_incs", (h_cnt - h0) + (m_cnt - m0), 0);
    check("both_blink", blink_mask, 0);
    s0 = s_cnt;
    drive_keys(1'b1, 1'b0, 5);
    check("both_exit_mode", mode, 0);
    check("both_exit_sec_clr", s_cnt - s0, 1);

    // Release of reset with MODE held low is a fresh press.
    @(negedge clk);
    key_mode = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("held_rst_mode", mode, 0);
    rst = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 8) key_mode = 1'b1;
      if (mode == 2'b01 && lat < 0) lat = i;
    end
    check("held_rst_latency", lat, 7);
    drive_keys(1'b1, 1'b0, 5);
    drive_keys(1'b1, 1'b0, 5);
    check("held_rst_back", mode, 0);

    // Asynchronous reset in the middle of an INC press in ADJ_MIN.
    drive_keys(1'b1, 1'b0, 5);
    drive_keys(1'b1, 1'b0, 5);
    check("pre_async_mode", mode, 2);
    m0 = m_cnt;
    @(negedge clk);
    key_inc = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_mode", mode, 0);
    check("async_rst_run_en", run_en, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    key_inc = 1'b1;
    repeat (20) @(negedge clk);
    check("async_rst_min_inc", m_cnt - m0, 0);
    check("async_rst_final_mode", mode, 0);

    check("pulse_exclusive", excl_err, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case a wait above is ever stuck.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/clock_mode_ctrl.md
CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4: consecutive clocks a synchronized key level must differ from the debounced level before it is accepted.
REQ-002 SHALL have parameter TIMEOUT_S, default 10: sec_tick count without a key press after which an adjust state exits.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 key_mode  in  1  raw MODE key, active-low, asynchronous to clk, bouncy.
REQ-006 key_inc  in  1  raw INC key, active-low, asynchronous to clk, bouncy.
REQ-007 sec_tick  in  1  one-clock pulse per second from the timebase.
REQ-008 mode  out  2  current state: 00 NORMAL, 01 ADJ_HOUR, 10 ADJ_MIN; 11 never driven.
REQ-009 run_en  out  1  time counter advance enable.
REQ-010 hour_inc  out  1  one-clock pulse: increment hours.
REQ-011 min_inc  out  1  one-clock pulse: increment minutes.
REQ-012 sec_clr  out  1  one-clock pulse: clear seconds to 00.
REQ-013 blink_mask  out  6  per-digit blank request to the display scanner; bits 5:4 hours, 3:2 minutes, 1:0 seconds; 1 = blank.

Function
REQ-014 Each key SHALL pass a 2-FF synchronizer, then a debouncer: counter increments while synced level differs from debounced level, clears when equal; debounced level flips when counter reaches DB_CYCLES, counter clears.
REQ-015 A press event SHALL be a one-clock internal pulse on each debounced 1->0 transition; release (0->1) SHALL generate no event.
REQ-016 Any low pulse shorter than DB_CYCLES clocks after synchronization SHALL produce no event.
REQ-017 Latency from first clock edge sampling a key low (held low) to the resulting registered output change SHALL be exactly DB_CYCLES+3 clocks.
REQ-018 MODE event transitions: NORMAL->ADJ_HOUR, ADJ_HOUR->ADJ_MIN, ADJ_MIN->NORMAL.
REQ-019 On ADJ_MIN->NORMAL via MODE event, sec_clr SHALL pulse for exactly one clock, coincident with the first NORMAL cycle of mode.
REQ-020 INC event in ADJ_HOUR SHALL pulse hour_inc one clock; in ADJ_MIN SHALL pulse min_inc one clock; in NORMAL SHALL be ignored.
REQ-021 MODE and INC events in the same clock: MODE SHALL act, INC SHALL be discarded.
REQ-022 run_en SHALL be 1 in NORMAL and 0 in both adjust states.
REQ-023 Idle counter SHALL clear on entry to an adjust state and on every MODE or INC event, increment on each sec_tick while in an adjust state, and saturate at TIMEOUT_S.
REQ-024 When idle counter reaches TIMEOUT_S, the state SHALL return to NORMAL on the next clock, with no sec_clr and no inc pulse; an event in that same clock takes priority and clears the counter.
REQ-025 blink_phase SHALL clear on entry to any state, toggle on each sec_tick in adjust states, and hold 0 in NORMAL.
REQ-026 blink_mask SHALL be 110000 in ADJ_HOUR and 001100 in ADJ_MIN when blink_phase=1, else 000000; registered, with no combinational path from key inputs.
REQ-027 hour_inc, min_inc and sec_clr SHALL be mutually exclusive in any clock.

Reset
REQ-028 During rst: mode=00, run_en=1, hour_inc=min_inc=sec_clr=0, blink_mask=000000, synchronizer and debounced levels =1 (released), all counters =0.
REQ-029 Release of rst with keys held low SHALL be treated as a fresh press after full debounce; no event SHALL be generated by rst itself.
REQ-030 rst asserted mid-adjust SHALL force outputs to reset values immediately, without waiting for clk, and discard in-flight debounce state.

Verification (DB_CYCLES=4, TIMEOUT_S=3, 50 clocks per sec_tick)
REQ-031 rst=1, keys=1 for 5 clocks, release -> mode=00, run_en=1, all pulses 0, blink_mask=000000 for 100 clocks.
REQ-032 key_mode low 5 clocks -> mode=01 and run_en=0 exactly 7 clocks after first low sample; separate 3-clock low glitch -> no change.
REQ-033 Full adjust sequence: MODE, INC x2, MODE, INC x3, MODE -> exactly 2 hour_inc, 3 min_inc, 1 sec_clr pulse on return to mode=00, run_en=1.
REQ-034 ADJ_MIN, no keys -> blink_mask 001100 after 1st sec_tick, 000000 after 2nd; mode=00 one clock after 3rd sec_tick, sec_clr stays 0.
REQ-035 key_mode and key_inc falling on the same clock in ADJ_HOUR -> mode=10, no hour_inc/min_inc pulse.
REQ-036 rst pulsed mid-INC-press in ADJ_MIN -> mode=00 asynchronously; no min_inc after release while key returns high.
